// File: rtl/offset_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : offset_stream_decoder
// Purpose  : Receive-side decoder for the offset-encoded byte stream.
//            d = enc - key_a + key_b (mod 256), x = ~d[7:4], y = ~d[3:0].
//            Decoded words {x, y, last} are buffered in an output FIFO with
//            valid/ready handshakes on both sides.
// Options  : `define CHECKSUM_EN builds the per-frame running sum of {x, y}
//            (sum_valid_o / frame_sum_o); otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module offset_stream_decoder #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_load_i,
  input  logic [7:0] key_a_i,
  input  logic [7:0] key_b_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_x_o,
  output logic [3:0] out_y_o,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       sum_valid_o,
  output logic [7:0] frame_sum_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    key_a_q;
  logic [7:0]    key_b_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [8:0]    mem_q [DEPTH];

  logic [7:0]    dec_d;
  logic [3:0]    dec_x;
  logic [3:0]    dec_y;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Pointers differ only in the wrap bit when every slot is occupied.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // in_ready is held low while reset is asserted, so the first edge after
  // release can already accept a byte.
  assign in_ready_o  = rst_n & ~full;
  assign out_valid_o = ~empty;
  assign busy_o      = ~empty;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Decode from the registered keys, so a key_load on the accept edge
  // does not affect the byte being accepted.
  assign dec_d = in_data_i - key_a_q + key_b_q;
  assign dec_x = ~dec_d[7:4];
  assign dec_y = ~dec_d[3:0];

  assign {out_x_o, out_y_o, out_last_o} = mem_q[rd_ptr_q[AW-1:0]];

  // Key registers: captured on the key_load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_a_q <= 8'h00;
      key_b_q <= 8'h00;
    end else if (key_load_i) begin
      key_a_q <= key_a_i;
      key_b_q <= key_b_i;
    end
  end

  // FIFO pointers: push and pop advance independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage: cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {dec_x, dec_y, in_last_i};
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic [7:0] sum_q;
  logic       sum_valid_q;
  logic [7:0] acc_inc;

  assign acc_inc = acc_q + {dec_x, dec_y};

  // Running sum for the current frame; clears after the last byte.
  always_comb begin
    acc_d = acc_q;
    if (push) acc_d = in_last_i ? 8'h00 : acc_inc;
  end

  // Accumulator, published frame sum and its one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 8'h00;
      sum_q       <= 8'h00;
      sum_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sum_valid_q <= push & in_last_i;
      if (push && in_last_i) sum_q <= acc_inc;
    end
  end

  assign sum_valid_o = sum_valid_q;
  assign frame_sum_o = sum_q;
`else
  assign sum_valid_o = 1'b0;
  assign frame_sum_o = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_offset_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_offset_stream_decoder
// Purpose  : Scoreboard bench for offset_stream_decoder. Expected words are
//            queued when a byte is accepted; a monitor pops and compares
//            whenever the DUT hands over a word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_offset_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       key_load;
  logic [7:0] key_a;
  logic [7:0] key_b;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic       out_last;
  logic       busy;
  logic       sum_valid;
  logic [7:0] frame_sum;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb_q[$];

  offset_stream_decoder #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_load_i(key_load), .key_a_i(key_a), .key_b_i(key_b),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_x_o(out_x), .out_y_o(out_y), .out_last_o(out_last),
    .busy_o(busy), .sum_valid_o(sum_valid), .frame_sum_o(frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handover happens at the next edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h, expected none", {out_x, out_y, out_last});
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        if ({out_x, out_y, out_last} !== e) begin
          n_bad++;
          $display("FAIL word: got x=%0h y=%0h last=%0b, expected x=%0h y=%0h last=%0b",
                   out_x, out_y, out_last, e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic load_keys(input logic [7:0] a, input logic [7:0] b);
    key_a = a; key_b = b; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // Present a byte until accepted; the hand-computed result is queued
  // at the negedge preceding the accepting edge.
  task automatic send(input logic [7:0] enc, input logic last,
                      input logic [3:0] ex, input logic [3:0] ey);
    bit done = 0;
    in_valid = 1'b1; in_data = enc; in_last = last;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({ex, ey, last});
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_a = 8'h00; key_b = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_head", {out_x, out_y, out_last}, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_frame_sum", frame_sum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Basic decode: 0xD5 - 0x10 + 0x05 = 0xCA -> x=3, y=5
    load_keys(8'h10, 8'h05);
    send(8'hD5, 1'b0, 4'h3, 4'h5);
    check("latency_out_valid", out_valid, 1);
    check("latency_busy", busy, 1);
    @(posedge clk); #1;
    check("drained_out_valid", out_valid, 0);

    // Wrap-around: 0xEF - 0xF0 = 0xFF -> 0,0 ; 0x00 - 0xF0 = 0x10 -> E,F
    load_keys(8'hF0, 8'h00);
    send(8'hEF, 1'b0, 4'h0, 4'h0);
    send(8'h00, 1'b1, 4'hE, 4'hF);

    // Key change on the accept edge: 0x20 with old keys -> 0x30 -> C,F;
    // next 0x20 with a=01,b=02 -> 0x21 -> D,E
    key_a = 8'h01; key_b = 8'h02; key_load = 1'b1;
    in_valid = 1'b1; in_data = 8'h20; in_last = 1'b0;
    @(negedge clk);
    check("keychg_in_ready", in_ready, 1);
    if (in_ready) sb_q.push_back({4'hC, 4'hF, 1'b0});
    @(posedge clk); #1;
    key_load = 1'b0; in_valid = 1'b0;
    send(8'h20, 1'b0, 4'hD, 4'hE);

    // Back-pressure with keys 0: enc n -> x=F, y=~n
    load_keys(8'h00, 8'h00);
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(8'(i), 1'b0, 4'hF, ~4'(i));
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    fork
      send(8'h04, 1'b0, 4'hF, 4'hB);
      begin
        repeat (3) @(posedge clk);
        #2;
        check("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    send(8'h05, 1'b1, 4'hF, 4'hA);
    repeat (8) @(posedge clk); #1;
    check("bp_drained", sb_q.size(), 0);
    check("bp_empty", out_valid, 0);

    // Reset mid-stream with three words buffered
    load_keys(8'h10, 8'h05);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hD5, 1'b0, 4'h3, 4'h5);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    // keys back to 0: 0xD5 -> x=2, y=A
    send(8'hD5, 1'b1, 4'h2, 4'hA);

`ifdef CHECKSUM_EN
    // Frame {x,y} = 35, 12, 01 -> sum 0x48
    send(8'hCA, 1'b0, 4'h3, 4'h5);
    send(8'hED, 1'b0, 4'h1, 4'h2);
    send(8'hFE, 1'b1, 4'h0, 4'h1);
    check("sum_valid_pulse", sum_valid, 1);
    check("frame_sum", frame_sum, 8'h48);
    @(posedge clk); #1;
    check("sum_valid_drop", sum_valid, 0);
    check("frame_sum_hold", frame_sum, 8'h48);
`else
    send(8'hCA, 1'b1, 4'h3, 4'h5);
    #1;
    check("nosum_valid", sum_valid, 0);
    check("nosum_frame", frame_sum, 0);
`endif

    for (int c = 0; c < 50 && sb_q.size() != 0; c++) @(posedge clk);
    #1;
    check("final_sb_empty", sb_q.size(), 0);
    check("final_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
